snoop_bus_ctrl: RTL
===================

# snoop_bus_ctrl

Sequencer for the shared MESI snoop bus. It sits directly behind the round-robin bus arbiter and runs each granted transaction to completion: it latches the winner's command, broadcasts the snoop, collects every other cache's response and picks the data source (dirty owner or memory). It also drives any required memory write-back or read, returns data to the requester, and holds the arbiter's `busy` input high for the whole transaction.

## Interface
Parameters:
- `ADDR_W`, 32: line address width.
- `LINE_W`, 256: cache line width in bits.
- `NUM_CPUS`, taken from `types` package: number of caches on the bus.

Ports:
- `clk`, in, 1: single clock; every register updates on its rising edge.
- `rst`, in, 1: synchronous, active-high.
- `gnt`, in, NUM_CPUS: one-hot grant from the arbiter.
- `cpu_cmd`, in, NUM_CPUS x bus_cmd_t: per-CPU pending command.
- `cpu_addr`, in, NUM_CPUS x ADDR_W: per-CPU request address.
- `cpu_wdata`, in, NUM_CPUS x LINE_W: per-CPU line for FLUSH.
- `bus_busy`, out, 1: transaction in flight; feeds the arbiter `busy` input.
- `snoop_valid`, out, 1: snoop broadcast active.
- `snoop_cmd`, out, bus_cmd_t: latched command.
- `snoop_addr`, out, ADDR_W: latched address.
- `snoop_src`, out, $clog2(NUM_CPUS): requester index.
- `snoop_ack`, in, NUM_CPUS: one-cycle response pulse per cache.
- `snoop_hit`, in, NUM_CPUS: cache holds the line; sampled with the ack.
- `snoop_dirty`, in, NUM_CPUS: cache holds the line in M; sampled with the ack.
- `snoop_data`, in, NUM_CPUS x LINE_W: owner data; sampled with the ack.
- `mem_read`, out, 1: memory read request.
- `mem_write`, out, 1: memory write request.
- `mem_addr`, out, ADDR_W: memory address.
- `mem_wdata`, out, LINE_W: memory write data.
- `mem_rdata`, in, LINE_W: memory read data.
- `mem_resp`, in, 1: memory completion pulse.
- `done`, out, NUM_CPUS: one-cycle completion pulse to the requester.
- `resp_data`, out, LINE_W: returned line; valid while `done` is high.
- `resp_shared`, out, 1: another cache hit on a BUS_RD; requester installs in S rather than E.

## Operation
- FSM states: IDLE, SNOOP, WB, MEM_RD, RESP.
- IDLE:
  - Any `gnt` bit set: latch index (lowest set bit if several), `cpu_cmd`, `cpu_addr`, `cpu_wdata`.
  - Initialise the ack mask with the requester's bit already set.
  - Next state: WB for BUS_FLUSH; SNOOP for every other command.
- SNOOP:
  - `snoop_valid`=1.
  - OR `snoop_ack` into the mask; the requester's own ack is ignored.
  - On each ack, accumulate hit into the shared flag; record the first dirty responder; capture its `snoop_data`.
  - Once the mask is all-ones (including acks arriving this cycle), take the first matching rule:
    - BUS_UPGR → RESP.
    - Dirty owner → WB, with write data = owner line.
    - Otherwise → MEM_RD.
- Multiple dirty responders is a protocol error: the lowest index wins; an assertion flags it.
- WB: `mem_write`=1, `mem_addr`=latched address, `mem_wdata`=latched line, all held until `mem_resp`, then RESP.
- MEM_RD: `mem_read`=1, held until `mem_resp`; capture `mem_rdata`; then RESP.
- RESP:
  - `done[src]`=1 for one cycle.
  - `resp_data`: owner, memory or zero data as applicable.
  - `resp_shared` = shared flag, BUS_RD only; 0 otherwise.
  - Next state IDLE.
- `bus_busy` = (state != IDLE), driven from registered state.
- `gnt` arriving while not in IDLE is ignored; the arbiter cannot produce this while `bus_busy` is high.

## Timing
- Reset: state IDLE; every output 0; mask and captured data cleared.
- Reset mid-transaction aborts it: every strobe is low the cycle after `rst`, and no `done` is issued.
- Grant at cycle t → `bus_busy` and `snoop_valid` high at t+1.
- The arbiter can issue the next grant in the first cycle the block is back in IDLE.
- BUS_UPGR with all acks at t+1: RESP at t+2 (`done`), IDLE at t+3.
- Memory ops: request asserted the cycle after entering WB/MEM_RD is decided; `mem_resp` at cycle m → RESP at m+1.
- Acks may arrive in any order and over any number of cycles; no timeout.
- An ack pulse coincident with the final transition is still counted.

## Structure
- `types` package holds:
  - `NUM_CPUS`.
  - `bus_cmd_t` (2-bit enum: BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_FLUSH=3).
  - FSM state enum `bus_state_t`.
- One sub-module: `snoop_resp_collector`. It contains the ack mask, the shared flag, the dirty-owner priority encoder and the owner data capture, and it signals `all_acked`.
- The arbiter remains a separate instance; `bus_busy` connects to its `busy` input.

## Test plan
- Reset with an active grant → all outputs 0; state stays IDLE while `rst` is held.
- CPU1 BUS_RD, 4 CPUs, nobody hits, `mem_resp` 5 cycles after `mem_read` with rdata=0xA5.. → `done`=4'b0010, `resp_data`=0xA5.., `resp_shared`=0, `mem_write` never high.
- CPU0 BUS_RDX, CPU2 acks dirty with 0x3C.. → `mem_write` to the latched address with 0x3C.., then `done`=4'b0001 with 0x3C.., no `mem_read`.
- CPU3 BUS_UPGR, acks spread over 3 cycles in reverse order → `done`[3] exactly one cycle after the last ack; no memory traffic.
- CPU2 BUS_FLUSH → `snoop_valid` never high, `mem_write` with `cpu_wdata`[2], `done`[2] one cycle after `mem_resp`.
- `rst` asserted while in MEM_RD → `mem_read` and `bus_busy` low next cycle, no `done`, next grant processed normally.

Source files
------------

// File: rtl/types.sv
// Shared types for the MESI snoop bus: CPU count, bus commands and sequencer states.
package types;

  localparam int unsigned NUM_CPUS  = 4;
  localparam int unsigned CPU_IDX_W = $clog2(NUM_CPUS);

  typedef enum logic [1:0] {
    BUS_RD    = 2'd0,
    BUS_RDX   = 2'd1,
    BUS_UPGR  = 2'd2,
    BUS_FLUSH = 2'd3
  } bus_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StWb,
    StMemRd,
    StResp
  } bus_state_t;

endpackage

// File: rtl/snoop_resp_collector.sv
// Gathers snoop responses for one transaction: ack mask, shared flag and first dirty owner.
// Outputs include acks arriving this cycle so the sequencer can decide without a bubble.
module snoop_resp_collector
  import types::*;
#(
  parameter int unsigned LINE_W = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic [CPU_IDX_W-1:0]       init_src,
  input  logic                       en,
  input  logic [NUM_CPUS-1:0]        ack,
  input  logic [NUM_CPUS-1:0]        hit,
  input  logic [NUM_CPUS-1:0]        dirty,
  input  logic [NUM_CPUS*LINE_W-1:0] data,
  output logic                       all_acked,
  output logic                       shared,
  output logic                       owner_valid,
  output logic [LINE_W-1:0]          owner_data
);

  logic [NUM_CPUS-1:0] mask_q, mask_d;
  logic                shared_q, shared_d;
  logic                owner_valid_q, owner_valid_d;
  logic [LINE_W-1:0]   owner_data_q, owner_data_d;
  logic [NUM_CPUS-1:0] ack_eff;
  logic [NUM_CPUS-1:0] dirty_acks;

  always_comb begin
    // Bits already in the mask (including the requester) never count twice.
    ack_eff       = en ? (ack & ~mask_q) : '0;
    dirty_acks    = ack_eff & dirty;
    mask_d        = mask_q | ack_eff;
    shared_d      = shared_q | (|(ack_eff & hit));
    owner_valid_d = owner_valid_q;
    owner_data_d  = owner_data_q;
    for (int i = 0; i < int'(NUM_CPUS); i++) begin
      if (!owner_valid_d && dirty_acks[i]) begin
        owner_valid_d = 1'b1;
        owner_data_d  = data[i*LINE_W +: LINE_W];
      end
    end
    if (init) begin
      mask_d           = '0;
      mask_d[init_src] = 1'b1;
      shared_d         = 1'b0;
      owner_valid_d    = 1'b0;
      owner_data_d     = '0;
    end
    all_acked   = &mask_d;
    shared      = shared_d;
    owner_valid = owner_valid_d;
    owner_data  = owner_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q        <= '0;
      shared_q      <= 1'b0;
      owner_valid_q <= 1'b0;
      owner_data_q  <= '0;
    end else begin
      mask_q        <= mask_d;
      shared_q      <= shared_d;
      owner_valid_q <= owner_valid_d;
      owner_data_q  <= owner_data_d;
    end
  end

  // More than one Modified copy of a line is a coherence protocol violation.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!((|dirty_acks) &&
                (owner_valid_q || ((dirty_acks & (dirty_acks - 1'b1)) != '0))));
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snoop bus sequencer: runs one granted transaction through snoop, write-back or memory
// read, and response, holding bus_busy high until it returns to idle.
module snoop_bus_ctrl
  import types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CPUS-1:0]        gnt,
  input  logic [NUM_CPUS*2-1:0]      cpu_cmd,
  input  logic [NUM_CPUS*ADDR_W-1:0] cpu_addr,
  input  logic [NUM_CPUS*LINE_W-1:0] cpu_wdata,
  output logic                       bus_busy,
  output logic                       snoop_valid,
  output logic [1:0]                 snoop_cmd,
  output logic [ADDR_W-1:0]          snoop_addr,
  output logic [CPU_IDX_W-1:0]       snoop_src,
  input  logic [NUM_CPUS-1:0]        snoop_ack,
  input  logic [NUM_CPUS-1:0]        snoop_hit,
  input  logic [NUM_CPUS-1:0]        snoop_dirty,
  input  logic [NUM_CPUS*LINE_W-1:0] snoop_data,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_resp,
  output logic [NUM_CPUS-1:0]        done,
  output logic [LINE_W-1:0]          resp_data,
  output logic                       resp_shared
);

  bus_state_t             state_q, state_d;
  logic [CPU_IDX_W-1:0]   src_q, src_d;
  bus_cmd_t               cmd_q, cmd_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [NUM_CPUS-1:0]    done_q, done_d;
  logic [LINE_W-1:0]      resp_data_q, resp_data_d;
  logic                   resp_shared_q, resp_shared_d;

  logic                   gnt_any;
  logic [CPU_IDX_W-1:0]   gnt_idx;
  bus_cmd_t               sel_cmd;
  logic [ADDR_W-1:0]      sel_addr;
  logic [LINE_W-1:0]      sel_wdata;
  logic [LINE_W-1:0]      resp_pick;
  logic                   coll_all_acked, coll_shared, coll_owner_valid;
  logic [LINE_W-1:0]      coll_owner_data;

  // Lowest set grant bit wins if the arbiter ever presents more than one.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    sel_cmd   = BUS_RD;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NUM_CPUS); i++) begin
      if (!gnt_any && gnt[i]) begin
        gnt_any   = 1'b1;
        gnt_idx   = CPU_IDX_W'(i);
        sel_cmd   = bus_cmd_t'(cpu_cmd[2*i +: 2]);
        sel_addr  = cpu_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = cpu_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  snoop_resp_collector #(
    .LINE_W (LINE_W)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .init        ((state_q == StIdle) && gnt_any),
    .init_src    (gnt_idx),
    .en          (state_q == StSnoop),
    .ack         (snoop_ack),
    .hit         (snoop_hit),
    .dirty       (snoop_dirty),
    .data        (snoop_data),
    .all_acked   (coll_all_acked),
    .shared      (coll_shared),
    .owner_valid (coll_owner_valid),
    .owner_data  (coll_owner_data)
  );

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    line_d    = line_q;
    resp_pick = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          src_d   = gnt_idx;
          cmd_d   = sel_cmd;
          addr_d  = sel_addr;
          line_d  = sel_wdata;
          state_d = (sel_cmd == BUS_FLUSH) ? StWb : StSnoop;
        end
      end
      StSnoop: begin
        if (coll_all_acked) begin
          if (cmd_q == BUS_UPGR) begin
            state_d = StResp;
          end else if (coll_owner_valid) begin
            state_d = StWb;
            line_d  = coll_owner_data;
          end else begin
            state_d = StMemRd;
          end
        end
      end
      StWb: begin
        if (mem_resp) begin
          state_d = StResp;
          if (cmd_q != BUS_FLUSH) resp_pick = line_q;
        end
      end
      StMemRd: begin
        if (mem_resp) begin
          state_d   = StResp;
          resp_pick = mem_rdata;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    done_d = '0;
    if (state_d == StResp) done_d[src_d] = 1'b1;
    resp_data_d   = resp_pick;
    resp_shared_d = (state_d == StResp) && (cmd_d == BUS_RD) && coll_shared;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      src_q         <= '0;
      cmd_q         <= BUS_RD;
      addr_q        <= '0;
      line_q        <= '0;
      done_q        <= '0;
      resp_data_q   <= '0;
      resp_shared_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      line_q        <= line_d;
      done_q        <= done_d;
      resp_data_q   <= resp_data_d;
      resp_shared_q <= resp_shared_d;
    end
  end

  assign bus_busy    = (state_q != StIdle);
  assign snoop_valid = (state_q == StSnoop);
  assign mem_write   = (state_q == StWb);
  assign mem_read    = (state_q == StMemRd);
  assign mem_addr    = (mem_write || mem_read) ? addr_q : '0;
  assign mem_wdata   = mem_write ? line_q : '0;
  assign snoop_cmd   = cmd_q;
  assign snoop_addr  = addr_q;
  assign snoop_src   = src_q;
  assign done        = done_q;
  assign resp_data   = resp_data_q;
  assign resp_shared = resp_shared_q;

endmodule
